pad_scan_ctrl: RTL and testbench
================================

# pad_scan_ctrl

Sequencer for the zero-padding stage of the conv datapath. It accepts one 32×3×4 feature-map tile from the upstream layer and pulses the padding register's load strobe. It then walks the output positions of the following 3×3 convolution over the padded 5×6 map, issuing one window request per position to the conv engine over a valid/ready handshake. It sits between the previous layer's output handshake, the padding register's `load` input, and the conv engine's window port.

## Interface

Parameters:

- `OUT_H`, default 3: output rows (window row positions).
- `OUT_W`, default 4: output columns (window column positions).
- `IDX_W`, default 2: width of the row and column index outputs. Must satisfy `2**IDX_W >= max(OUT_H, OUT_W)`.

Ports:

- `clk` input, 1: system clock; all state updates on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `start` input, 1: begin one tile. Sampled only in IDLE.
- `abort` input, 1: synchronous cancel. Effective in any state except IDLE.
- `in_valid` input, 1: upstream tile present on the padding register's `d` bus.
- `in_ready` output, 1: controller is ready to capture a tile.
- `pad_load` output, 1: load strobe to the padding register.
- `win_valid` output, 1: window request valid.
- `win_ready` input, 1: conv engine accepts the window.
- `win_row` output, `IDX_W`: output row index of the current window; the window's top-left corner in the padded map.
- `win_col` output, `IDX_W`: output column index of the current window.
- `win_last` output, 1: current window is the final one (`OUT_H-1`, `OUT_W-1`).
- `busy` output, 1: high in every state except IDLE.
- `done` output, 1: single-cycle pulse after the last window is accepted.

## Operation

States: IDLE, LOAD, SCAN, DONE. The state and the row/col counters are registered. All outputs are decoded from them.

- **IDLE**
  - `start`=1 → LOAD.
  - `in_valid` is ignored.
- **LOAD**
  - `in_ready`=1.
  - `pad_load = in_valid & in_ready & ~abort`, driven combinationally. The padding register captures the tile on that same edge.
  - On `pad_load` → SCAN, with row=0 and col=0.
- **SCAN**
  - `win_valid`=1. `win_row` and `win_col` come from the counters.
  - On `win_valid & win_ready`:
    - If col < `OUT_W-1`: col+1.
    - Otherwise: col=0 and row+1.
    - If `win_last` is also high: → DONE, and the counters clear to 0.
  - Without `win_ready`, state, `win_row` and `win_col` hold stable. `win_valid` does not drop once raised until its handshake completes.
- **DONE**
  - `done`=1 for exactly one cycle, then → IDLE.
  - `start` is not accepted in DONE.
- **abort**
  - From LOAD or SCAN: → IDLE next edge. Counters clear to 0 and `done` is not pulsed.
  - In LOAD, abort suppresses `pad_load` in the same cycle.
  - In DONE, abort has no effect; the `done` pulse completes normally.
- **start while busy**: ignored. It is not queued.
- **Window count**: exactly `OUT_H*OUT_W` handshakes per tile (12 at the defaults), in row-major order. The counters never exceed `OUT_H-1` / `OUT_W-1`.

## Timing

- Reset: state=IDLE, row=col=0. `in_ready`, `pad_load`, `win_valid`, `win_last`, `busy` and `done` are all 0, and `win_row`=`win_col`=0.
- `start` at edge N → LOAD, with `busy`=1 and `in_ready`=1 from cycle N+1.
- `in_valid` already high in LOAD's first cycle → `pad_load` in that cycle. `win_valid` rises on the next cycle, when the padded data is already valid in the padding register.
- With `win_ready` tied high: one window per cycle.
  - Minimum tile time from `start` sampled to `done` high is 1 (LOAD) + 12 (SCAN) = 13 cycles. `done` is asserted in cycle 14.
  - IDLE is reached in cycle 15.
- Async reset mid-tile: everything returns to reset values immediately, regardless of the handshake in flight.

## Test plan

1. **Reset.** Assert `rst_n`=0 mid-SCAN at row=1, col=2 → all outputs go to 0 asynchronously. After release, the block sits in IDLE with `busy`=0.
2. **Nominal tile.**
   - Stimulus: `start` pulse, `in_valid`=1, `win_ready`=1.
   - Required: `pad_load` high for exactly 1 cycle.
   - Required: 12 consecutive windows (0,0),(0,1),(0,2),(0,3),(1,0)…(2,3), with `win_last` only on (2,3).
   - Required: `done` 13 cycles after the LOAD cycle begins, then IDLE.
3. **Backpressure.** `win_ready` toggles 1,0,0,1,… → `win_row`/`win_col` are held and `win_valid` stays high while stalled. Still exactly 12 accepted handshakes, with no skipped or repeated index.
4. **Late input.** `in_valid` is held low for 5 cycles in LOAD → `in_ready` stays 1, there is no `pad_load` and no `win_valid`. When `in_valid`=1, `pad_load` pulses once and SCAN begins the next cycle.
5. **Abort.**
   - `abort` together with `in_valid` in LOAD → `pad_load`=0 and the block returns to IDLE.
   - `abort` in SCAN at (1,1) → IDLE next cycle, no `done`, and the counters are back at 0. A following `start` begins again from (0,0).
6. **Start while busy.** Pulse `start` during SCAN and during DONE → no effect. The tile completes normally and exactly one `done` is produced.

Source files
------------

// File: rtl/pad_scan_ctrl.sv
// Zero-padding sequencer: captures one feature-map tile into the padding register,
// then issues one 3x3 window request per output position in row-major order.
module pad_scan_ctrl #(
  parameter int OUT_H = 3,
  parameter int OUT_W = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             pad_load,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [IDX_W-1:0] win_row,
  output logic [IDX_W-1:0] win_col,
  output logic             win_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] ROW_MAX = IDX_W'(OUT_H - 1);
  localparam logic [IDX_W-1:0] COL_MAX = IDX_W'(OUT_W - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] row, col, row_nxt, col_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
    end
  end

  // Counters are only meaningful in SCAN; every exit path returns them to zero.
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    in_ready  = 1'b0;
    pad_load  = 1'b0;
    win_valid = 1'b0;
    win_last  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = LOAD;
        end
      end

      LOAD: begin
        in_ready = 1'b1;
        pad_load = in_valid & ~abort;
        if (abort) begin
          state_nxt = IDLE;
          row_nxt   = '0;
          col_nxt   = '0;
        end else if (in_valid) begin
          state_nxt = SCAN;
          row_nxt   = '0;
          col_nxt   = '0;
        end
      end

      SCAN: begin
        win_valid = 1'b1;
        win_last  = (row == ROW_MAX) && (col == COL_MAX);
        if (abort) begin
          state_nxt = IDLE;
          row_nxt   = '0;
          col_nxt   = '0;
        end else if (win_ready) begin
          if (win_last) begin
            state_nxt = DONE;
            row_nxt   = '0;
            col_nxt   = '0;
          end else if (col < COL_MAX) begin
            col_nxt = col + IDX_W'(1);
          end else begin
            col_nxt = '0;
            row_nxt = row + IDX_W'(1);
          end
        end
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
        row_nxt   = '0;
        col_nxt   = '0;
      end
    endcase
  end

  assign win_row = row;
  assign win_col = col;

endmodule

// File: tb/tb_pad_scan_ctrl.sv
// Scoreboard bench for pad_scan_ctrl: expected windows are queued as tiles are
// started and popped by a monitor on every accepted window handshake.
module tb_pad_scan_ctrl;

  localparam int OUT_H = 3;
  localparam int OUT_W = 4;
  localparam int IDX_W = 2;
  localparam int N_WIN = OUT_H * OUT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             in_valid = 1'b0;
  logic             win_ready = 1'b0;
  logic             in_ready, pad_load, win_valid, win_last, busy, done;
  logic [IDX_W-1:0] win_row, win_col;

  pad_scan_ctrl #(.OUT_H(OUT_H), .OUT_W(OUT_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .pad_load(pad_load),
    .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row),
    .win_col(win_col), .win_last(win_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int row;
    int col;
    bit last;
  } win_t;

  win_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  int   done_exp = 0;
  int   pad_seen = 0;
  int   pad_exp = 0;
  int   ready_mode = 0;
  int   ready_phase = 0;
  bit   prev_stall = 1'b0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Queue the first n_win windows of a tile in row-major order, then pulse start.
  task automatic applyStimulus(input int n_win, input int exp_done, input int exp_load);
    win_t w;
    for (int i = 0; i < n_win; i++) begin
      w.row  = i / OUT_W;
      w.col  = i % OUT_W;
      w.last = (i == N_WIN - 1);
      exp_q.push_back(w);
    end
    done_exp += exp_done;
    pad_exp  += exp_load;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && !done; i++) tick();
    checkOutput("done_reached", done, 1);
    tick();
    checkOutput("idle_after_done", busy, 0);
  endtask

  // win_ready driver: 0 = always high, 1 = 1,0,0 pattern, 2 = random, other = low
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: win_ready = 1'b1;
        1: begin
          win_ready = (ready_phase % 3 == 0);
          ready_phase++;
        end
        2: win_ready = 1'($urandom_range(0, 1));
        default: win_ready = 1'b0;
      endcase
    end
  end

  // Monitor: the displayed window must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) checkOutput("stall_valid_held", win_valid, 1);
      if (win_valid && exp_q.size() > 0) begin
        checkOutput("win_row", win_row, exp_q[0].row);
        checkOutput("win_col", win_col, exp_q[0].col);
        checkOutput("win_last", win_last, exp_q[0].last);
      end
      if (win_valid && win_ready && !abort) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL win_extra: got window (%0d,%0d), expected none", win_row, win_col);
        end else begin
          void'(exp_q.pop_front());
        end
      end
      prev_stall = win_valid && !win_ready && !abort;
      if (done) done_seen++;
      if (pad_load) pad_seen++;
    end
  end

  initial begin
    int n;
    int d;

    #12;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_win_valid", win_valid, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_row", win_row, 0);
    checkOutput("rst_col", win_col, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] nominal tile with start pulses while busy");
    ready_mode = 0;
    in_valid   = 1'b1;
    applyStimulus(N_WIN, 1, 1);
    checkOutput("load_busy", busy, 1);
    checkOutput("load_in_ready", in_ready, 1);
    checkOutput("load_pad_load", pad_load, 1);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
      start = (n == 5);
    end
    start = 1'b0;
    checkOutput("done_latency", n, 13);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("start_in_done_ignored", busy, 0);
    tick();
    checkOutput("idle_stays", busy, 0);
    checkOutput("idle_in_ready", in_ready, 0);

    $display("[TB] backpressure 1,0,0 pattern");
    ready_mode  = 1;
    ready_phase = 0;
    applyStimulus(N_WIN, 1, 1);
    wait_done(200);

    $display("[TB] late input");
    ready_mode = 2;
    in_valid   = 1'b0;
    applyStimulus(N_WIN, 1, 1);
    repeat (5) begin
      checkOutput("late_in_ready", in_ready, 1);
      checkOutput("late_no_load", pad_load, 0);
      checkOutput("late_no_win", win_valid, 0);
      tick();
    end
    in_valid = 1'b1;
    #1;
    checkOutput("late_pad_load", pad_load, 1);
    tick();
    checkOutput("late_scan_valid", win_valid, 1);
    checkOutput("late_scan_row", win_row, 0);
    checkOutput("late_scan_col", win_col, 0);
    wait_done(200);

    $display("[TB] abort in LOAD");
    ready_mode = 0;
    applyStimulus(0, 0, 0);
    abort = 1'b1;
    #1;
    checkOutput("abort_load_no_pad", pad_load, 0);
    checkOutput("abort_load_in_ready", in_ready, 1);
    tick();
    abort = 1'b0;
    checkOutput("abort_load_idle", busy, 0);
    tick();
    checkOutput("abort_load_stays_idle", busy, 0);

    $display("[TB] abort in SCAN at (1,1)");
    applyStimulus(5, 0, 1);
    for (int i = 0; i < 40 && !(win_valid && win_row == 1 && win_col == 1); i++) tick();
    checkOutput("reach_1_1", int'(win_valid && win_row == 1 && win_col == 1), 1);
    ready_mode = 3;
    abort      = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_scan_idle", busy, 0);
    checkOutput("abort_scan_valid", win_valid, 0);
    checkOutput("abort_scan_row", win_row, 0);
    checkOutput("abort_scan_col", win_col, 0);
    checkOutput("abort_scan_no_done", done, 0);
    tick();
    checkOutput("abort_scan_still_no_done", done, 0);

    $display("[TB] restart after abort");
    ready_mode = 0;
    applyStimulus(N_WIN, 1, 1);
    tick();
    checkOutput("restart_valid", win_valid, 1);
    checkOutput("restart_row", win_row, 0);
    checkOutput("restart_col", win_col, 0);
    wait_done(200);

    $display("[TB] async reset mid-scan at (1,2)");
    applyStimulus(6, 0, 1);
    for (int i = 0; i < 40 && !(win_valid && win_row == 1 && win_col == 2); i++) tick();
    checkOutput("reach_1_2", int'(win_valid && win_row == 1 && win_col == 2), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_valid", win_valid, 0);
    checkOutput("arst_last", win_last, 0);
    checkOutput("arst_row", win_row, 0);
    checkOutput("arst_col", win_col, 0);
    checkOutput("arst_in_ready", in_ready, 0);
    checkOutput("arst_pad_load", pad_load, 0);
    checkOutput("arst_done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("arst_release_idle", busy, 0);
    checkOutput("arst_release_valid", win_valid, 0);

    $display("[TB] random tiles");
    for (int t = 0; t < 4; t++) begin
      ready_mode = 2;
      in_valid   = 1'b0;
      applyStimulus(N_WIN, 1, 1);
      d = $urandom_range(0, 3);
      repeat (d) tick();
      in_valid = 1'b1;
      wait_done(300);
    end

    tick();
    checkOutput("done_count", done_seen, done_exp);
    checkOutput("pad_load_count", pad_seen, pad_exp);
    checkOutput("windows_outstanding", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
